tdc_fine_reader: RTL and testbench

- Consumer side of the TDC fine delay line.
- Drives the Start/Stop column capture enables of the carry-chain fine stage and reads back the Start and Stop thermometer columns.
- Converts each captured code to a tap count and counts clock cycles between the Start and Stop captures.
- Presents one measurement per armed run on a valid/ready output toward the histogram/readout logic.

---
 rtl/tdc_fine_reader.sv | 154 +++++++++++++++
 tb/tb_tdc_fine_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_fine_reader.sv
// Sequences the Start/Stop capture columns of the carry-chain fine stage, encodes both thermometer
// codes and counts coarse cycles between captures. Optional build macro: TDC_BUBBLE_FILTER_EN.
module tdc_fine_reader #(
    parameter int NUM = 12,
    parameter int CW  = 16,
    localparam int OW = $clog2(NUM + 1),
    localparam int IW = CW + OW + 1
) (
    input  logic          clk,
    input  logic          iRst,
    input  logic          iArm,
    input  logic [NUM-1:0] iFFStart,
    input  logic [NUM-1:0] iFFStop,
    output logic          oStartEnable,
    output logic          oStopEnable,
    output logic          oValid,
    input  logic          iReady,
    output logic [OW-1:0] oStartOnes,
    output logic [OW-1:0] oStopOnes,
    output logic [CW-1:0] oCoarse,
    output logic [IW-1:0] oInterval,
    output logic          oOverflow,
    output logic          oBusy
);

    typedef enum logic [2:0] {
        IDLE,
        START_FLUSH,
        ARM_START,
        WAIT_LOW,
        STOP_FLUSH,
        ARM_STOP,
        ENCODE,
        OUT
    } stateT;

    localparam logic [CW-1:0] COARSE_MAX = '1;

    stateT          state;
    stateT          stateNext;
    logic [NUM-1:0] startCode;
    logic [NUM-1:0] stopCode;
    logic [CW-1:0]  coarse;
    logic [CW-1:0]  coarseInc;
    logic           overflowFlag;
    logic [OW-1:0]  startOnes;
    logic [OW-1:0]  stopOnes;
    logic [IW-1:0]  intervalCalc;

    // Filtered build counts every set bit; plain build counts only the unbroken run from bit 0.
    function automatic logic [OW-1:0] onesCount(input logic [NUM-1:0] code);
        logic [OW-1:0] count;
        count = '0;
        for (int i = 0; i < NUM; i++) begin
`ifdef TDC_BUBBLE_FILTER_EN
            if (code[i]) count = count + OW'(1);
`else
            if (code[i] && (count == OW'(i))) count = count + OW'(1);
`endif
        end
        return count;
    endfunction

    assign coarseInc    = (coarse == COARSE_MAX) ? coarse : coarse + CW'(1);
    assign startOnes    = onesCount(startCode);
    assign stopOnes     = onesCount(stopCode);
    assign intervalCalc = IW'(coarse) * IW'(NUM) + IW'(startOnes) - IW'(stopOnes);

    always_ff @(posedge clk) begin
        if (iRst) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext    = state;
        oStartEnable = 1'b0;
        oStopEnable  = 1'b0;
        oValid       = 1'b0;
        oBusy        = (state != IDLE);
        case (state)
            IDLE:        if (iArm) stateNext = START_FLUSH;
            START_FLUSH: begin
                oStartEnable = 1'b1;
                stateNext    = ARM_START;
            end
            ARM_START: begin
                oStartEnable = 1'b1;
                if (iFFStart != '0) stateNext = WAIT_LOW;
            end
            WAIT_LOW: begin
                oStartEnable = 1'b1;
                if (iFFStart == '0) stateNext = STOP_FLUSH;
            end
            STOP_FLUSH: begin
                oStopEnable = 1'b1;
                stateNext   = ARM_STOP;
            end
            ARM_STOP: begin
                oStopEnable = 1'b1;
                if ((iFFStop != '0) || (coarseInc == COARSE_MAX)) stateNext = ENCODE;
            end
            ENCODE:      stateNext = OUT;
            OUT: begin
                oValid = 1'b1;
                if (iReady) stateNext = IDLE;
            end
            default:     stateNext = IDLE;
        endcase
    end

    // A Stop hit on the saturating edge wins over overflow, so a genuine capture is never discarded.
    always_ff @(posedge clk) begin
        if (iRst) begin
            startCode    <= '0;
            stopCode     <= '0;
            coarse       <= '0;
            overflowFlag <= 1'b0;
            oStartOnes   <= '0;
            oStopOnes    <= '0;
            oCoarse      <= '0;
            oInterval    <= '0;
            oOverflow    <= 1'b0;
        end else begin
            case (state)
                ARM_START: begin
                    if (iFFStart != '0) begin
                        startCode    <= iFFStart;
                        coarse       <= '0;
                        overflowFlag <= 1'b0;
                    end
                end
                WAIT_LOW, STOP_FLUSH: coarse <= coarseInc;
                ARM_STOP: begin
                    coarse <= coarseInc;
                    if (iFFStop != '0) begin
                        stopCode <= iFFStop;
                    end else if (coarseInc == COARSE_MAX) begin
                        stopCode     <= '0;
                        overflowFlag <= 1'b1;
                    end
                end
                ENCODE: begin
                    oStartOnes <= startOnes;
                    oStopOnes  <= stopOnes;
                    oCoarse    <= coarse;
                    oInterval  <= intervalCalc;
                    oOverflow  <= overflowFlag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_fine_reader.sv
// Randomized bench for tdc_fine_reader (CW = 4 so saturation is reachable) against a tap-count model.
module tb_tdc_fine_reader;

    localparam int NUM = 12;
    localparam int CW  = 4;
    localparam int OW  = 4;
    localparam int IW  = 9;

    logic          clk = 1'b0;
    logic          iRst = 1'b1;
    logic          iArm = 1'b0;
    logic [NUM-1:0] iFFStart = '0;
    logic [NUM-1:0] iFFStop = '0;
    logic          iReady = 1'b0;
    logic          oStartEnable, oStopEnable, oValid, oOverflow, oBusy;
    logic [OW-1:0] oStartOnes, oStopOnes;
    logic [CW-1:0] oCoarse;
    logic [IW-1:0] oInterval;

    int total = 0;
    int bad = 0;

    tdc_fine_reader #(.NUM(NUM), .CW(CW)) dut (
        .clk(clk), .iRst(iRst), .iArm(iArm), .iFFStart(iFFStart), .iFFStop(iFFStop),
        .oStartEnable(oStartEnable), .oStopEnable(oStopEnable), .oValid(oValid), .iReady(iReady),
        .oStartOnes(oStartOnes), .oStopOnes(oStopOnes), .oCoarse(oCoarse), .oInterval(oInterval),
        .oOverflow(oOverflow), .oBusy(oBusy)
    );

    always #5 clk = ~clk;

    // Tap count of a captured code as the readout is meant to interpret it.
    function automatic int modelOnes(input logic [NUM-1:0] code);
`ifdef TDC_BUBBLE_FILTER_EN
        return $countones(code);
`else
        for (int i = 0; i < NUM; i++) if (!code[i]) return i;
        return NUM;
`endif
    endfunction

    function automatic logic [NUM-1:0] randomCode();
        int k;
        logic [NUM-1:0] code;
        k = $urandom_range(1, NUM);
        code = NUM'((1 << k) - 1);
        if (k >= 3 && $urandom_range(0, 1) == 1) code[$urandom_range(0, k - 2)] = 1'b0;
        return code;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walks one armed run: stale values sit on the flush cycles, hold counts Start edges kept high in
    // WAIT_LOW, gap counts empty ARM_STOP edges; returns edges from Stop drive to oValid.
    task automatic runMeasurement(input logic [NUM-1:0] staleStart, input int armGap,
                                  input logic [NUM-1:0] startCode, input int hold,
                                  input logic [NUM-1:0] staleStop, input int gap,
                                  input logic [NUM-1:0] stopCode, output int latency);
        iArm = 1'b1; step(); iArm = 1'b0;
        iFFStart = staleStart; step();
        iFFStart = '0; repeat (armGap) step();
        iFFStart = startCode; step();
        repeat (hold) step();
        iFFStart = '0; step();
        iFFStop = staleStop; step();
        iFFStop = '0; repeat (gap) step();
        iFFStop = stopCode;
        latency = 0;
        while (oValid !== 1'b1 && latency < 60) begin
            step();
            iFFStop = '0;
            latency++;
        end
    endtask

    task automatic handshake();
        iReady = 1'b1; step(); iReady = 1'b0;
    endtask

    task automatic test_reset();
        iRst = 1'b1; iArm = 1'b1; step(); step();
        total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", oBusy); end
        total++; if ({oStartEnable, oStopEnable, oValid, oOverflow} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {oStartEnable, oStopEnable, oValid, oOverflow}); end
        total++; if ({oStartOnes, oStopOnes, oCoarse, oInterval} !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", {oStartOnes, oStopOnes, oCoarse, oInterval}); end
        iRst = 1'b0; iArm = 1'b0; step();
        total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL reset_arm_ignored got=%0b want=0", oBusy); end
    endtask

    task automatic test_nominal();
        int lat;
        runMeasurement('0, 0, 12'h03F, 0, '0, 2, 12'h00F, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL nominal_latency got=%0d want=2", lat); end
        total++; if (oValid !== 1'b1) begin bad++; $display("FAIL nominal_valid got=%0b want=1", oValid); end
        total++; if (oStartOnes !== 4'd6) begin bad++; $display("FAIL nominal_start got=%0d want=6", oStartOnes); end
        total++; if (oStopOnes !== 4'd4) begin bad++; $display("FAIL nominal_stop got=%0d want=4", oStopOnes); end
        total++; if (oCoarse !== 4'd5) begin bad++; $display("FAIL nominal_coarse got=%0d want=5", oCoarse); end
        total++; if (oInterval !== 9'd62) begin bad++; $display("FAIL nominal_interval got=%0d want=62", oInterval); end
        total++; if (oOverflow !== 1'b0) begin bad++; $display("FAIL nominal_overflow got=%0b want=0", oOverflow); end
        handshake();
        total++; if ({oValid, oBusy} !== 2'b00) begin bad++; $display("FAIL nominal_release got=%b want=00", {oValid, oBusy}); end
        total++; if (oInterval !== 9'd62) begin bad++; $display("FAIL nominal_hold_idle got=%0d want=62", oInterval); end
    endtask

    task automatic test_enables();
        iArm = 1'b1; step(); iArm = 1'b0;
        total++; if ({oStartEnable, oStopEnable, oBusy} !== 3'b101) begin bad++; $display("FAIL en_start_flush got=%b want=101", {oStartEnable, oStopEnable, oBusy}); end
        step();
        total++; if ({oStartEnable, oStopEnable} !== 2'b10) begin bad++; $display("FAIL en_arm_start got=%b want=10", {oStartEnable, oStopEnable}); end
        iFFStart = 12'h001; step();
        total++; if ({oStartEnable, oStopEnable} !== 2'b10) begin bad++; $display("FAIL en_wait_low got=%b want=10", {oStartEnable, oStopEnable}); end
        iFFStart = '0; step();
        total++; if ({oStartEnable, oStopEnable} !== 2'b01) begin bad++; $display("FAIL en_stop_flush got=%b want=01", {oStartEnable, oStopEnable}); end
        iFFStop = 12'h003; step();
        total++; if ({oStartEnable, oStopEnable} !== 2'b01) begin bad++; $display("FAIL en_arm_stop got=%b want=01", {oStartEnable, oStopEnable}); end
        step(); iFFStop = '0;
        total++; if ({oStartEnable, oStopEnable, oValid, oBusy} !== 4'b0001) begin bad++; $display("FAIL en_encode got=%b want=0001", {oStartEnable, oStopEnable, oValid, oBusy}); end
        step();
        total++; if (oValid !== 1'b1) begin bad++; $display("FAIL en_out_valid got=%0b want=1", oValid); end
        total++; if (oCoarse !== 4'd3) begin bad++; $display("FAIL min_coarse got=%0d want=3", oCoarse); end
        total++; if (oInterval !== 9'(3 * NUM + 1 - modelOnes(12'h003))) begin bad++; $display("FAIL min_interval got=%0d want=%0d", oInterval, 3 * NUM + 1 - modelOnes(12'h003)); end
        handshake();
    endtask

    task automatic test_bubble();
        int lat;
        int ones;
        ones = modelOnes(12'h0BF);
        runMeasurement('0, 1, 12'h0BF, 0, '0, 2, 12'h00F, lat);
`ifdef TDC_BUBBLE_FILTER_EN
        total++; if (oStartOnes !== 4'd7) begin bad++; $display("FAIL bubble_start got=%0d want=7", oStartOnes); end
        total++; if (oInterval !== 9'd63) begin bad++; $display("FAIL bubble_interval got=%0d want=63", oInterval); end
`else
        total++; if (oStartOnes !== 4'd6) begin bad++; $display("FAIL bubble_start got=%0d want=6", oStartOnes); end
        total++; if (oInterval !== 9'd62) begin bad++; $display("FAIL bubble_interval got=%0d want=62", oInterval); end
`endif
        total++; if (oInterval !== 9'(5 * NUM + ones - 4)) begin bad++; $display("FAIL bubble_model got=%0d want=%0d", oInterval, 5 * NUM + ones - 4); end
        handshake();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [NUM-1:0] sc, pc;
        int expInterval;
        sc = randomCode(); pc = randomCode();
        expInterval = 6 * NUM + modelOnes(sc) - modelOnes(pc);
        runMeasurement('0, 0, sc, 1, '0, 2, pc, lat);
        iArm = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total++; if ({oValid, oBusy} !== 2'b11) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=11", i, {oValid, oBusy}); end
            total++; if ({oStartOnes, oStopOnes, oCoarse, oInterval, oOverflow} !== {4'(modelOnes(sc)), 4'(modelOnes(pc)), 4'd6, 9'(expInterval), 1'b0}) begin
                bad++; $display("FAIL bp_data[%0d] got=%0d/%0d/%0d/%0d want=%0d/%0d/6/%0d", i, oStartOnes, oStopOnes, oCoarse, oInterval, modelOnes(sc), modelOnes(pc), expInterval);
            end
        end
        iReady = 1'b1; step(); iReady = 1'b0; iArm = 1'b0;
        total++; if ({oValid, oBusy} !== 2'b00) begin bad++; $display("FAIL bp_release got=%b want=00", {oValid, oBusy}); end
        step();
        total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL bp_arm_in_out got=%0b want=0", oBusy); end
    endtask

    task automatic test_overflow();
        int lat;
        runMeasurement('0, 1, 12'h001, 0, '0, 0, '0, lat);
        total++; if (oValid !== 1'b1) begin bad++; $display("FAIL ovf_timeout got=%0b want=1", oValid); end
        total++; if (oCoarse !== 4'd15) begin bad++; $display("FAIL ovf_coarse got=%0d want=15", oCoarse); end
        total++; if (oStopOnes !== 4'd0) begin bad++; $display("FAIL ovf_stop got=%0d want=0", oStopOnes); end
        total++; if (oOverflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", oOverflow); end
        total++; if (oInterval !== 9'd181) begin bad++; $display("FAIL ovf_interval got=%0d want=181", oInterval); end
        handshake();
    endtask

    task automatic test_stale();
        int lat;
        runMeasurement(12'hFFF, 2, 12'h007, 1, 12'hFFF, 1, 12'h001, lat);
        total++; if (oStartOnes !== 4'd3) begin bad++; $display("FAIL stale_start got=%0d want=3", oStartOnes); end
        total++; if (oStopOnes !== 4'd1) begin bad++; $display("FAIL stale_stop got=%0d want=1", oStopOnes); end
        total++; if (oCoarse !== 4'd5) begin bad++; $display("FAIL stale_coarse got=%0d want=5", oCoarse); end
        total++; if (oInterval !== 9'd62) begin bad++; $display("FAIL stale_interval got=%0d want=62", oInterval); end
        handshake();
    endtask

    task automatic test_reset_midrun();
        int lat;
        iArm = 1'b1; step(); iArm = 1'b0; step();
        iFFStart = 12'h003; step(); iFFStart = '0; step(); step();
        iRst = 1'b1; step(); iRst = 1'b0;
        total++; if ({oBusy, oStopEnable, oValid} !== 3'b000) begin bad++; $display("FAIL rst_armstop got=%b want=000", {oBusy, oStopEnable, oValid}); end
        runMeasurement('0, 0, 12'h0FF, 2, '0, 1, 12'h01F, lat);
        total++; if ({oCoarse, oInterval} !== {4'd6, 9'(6 * NUM + modelOnes(12'h0FF) - modelOnes(12'h01F))}) begin
            bad++; $display("FAIL rst_rerun got=%0d/%0d want=6/%0d", oCoarse, oInterval, 6 * NUM + 8 - 5);
        end
        iRst = 1'b1; step(); iRst = 1'b0;
        total++; if ({oValid, oBusy, oStartOnes, oCoarse, oInterval} !== '0) begin bad++; $display("FAIL rst_out got=%h want=0", {oValid, oBusy, oStartOnes, oCoarse, oInterval}); end
    endtask

    task automatic test_random();
        int lat, hold, gap, expCoarse, expInterval;
        logic [NUM-1:0] sc, pc, ss, ps;
        for (int n = 0; n < 25; n++) begin
            sc = randomCode(); pc = randomCode();
            ss = NUM'($urandom); ps = NUM'($urandom);
            hold = $urandom_range(0, 4); gap = $urandom_range(0, 7);
            expCoarse = hold + gap + 3;
            expInterval = expCoarse * NUM + modelOnes(sc) - modelOnes(pc);
            runMeasurement(ss, $urandom_range(0, 3), sc, hold, ps, gap, pc, lat);
            total++; if (lat !== 2) begin bad++; $display("FAIL rnd_latency[%0d] got=%0d want=2", n, lat); end
            total++; if ({oStartOnes, oStopOnes} !== {4'(modelOnes(sc)), 4'(modelOnes(pc))}) begin
                bad++; $display("FAIL rnd_ones[%0d] got=%0d/%0d want=%0d/%0d", n, oStartOnes, oStopOnes, modelOnes(sc), modelOnes(pc));
            end
            total++; if ({oCoarse, oOverflow} !== {4'(expCoarse), 1'b0}) begin bad++; $display("FAIL rnd_coarse[%0d] got=%0d/%0b want=%0d/0", n, oCoarse, oOverflow, expCoarse); end
            total++; if (oInterval !== 9'(expInterval)) begin bad++; $display("FAIL rnd_interval[%0d] got=%0d want=%0d", n, oInterval, expInterval); end
            repeat ($urandom_range(0, 3)) step();
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_enables();
        test_bubble();
        test_backpressure();
        test_overflow();
        test_stale();
        test_reset_midrun();
        test_random();
        test_nominal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
